pspin_cmd_tracker: RTL and testbench

Parametrised command-slot tracker for the cluster command path. It allocates a per-core local command ID, limits the number of commands in flight per command interface, and retires commands on response. It emits a registered per-core completion and flags responses to IDs that were never allocated. It sits between the HPU drivers (command issue) and the command unit (request/response routing).

---
 rtl/pspin_cfg_pkg.sv | 23 ++
 rtl/pspin_cmd_tracker_if.sv | 34 +++
 rtl/pspin_first_free.sv | 23 ++
 rtl/pspin_cmd_tracker.sv | 146 ++++++++++++++
 tb/tb_pspin_cmd_tracker.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pspin_cfg_pkg.sv
// Shared configuration for the cluster command path: default sizes, the
// command-ID layout and the in-flight counter width helper.
package pspin_cfg_pkg;

  localparam int NUM_HPU_CMDS       = 4;
  localparam int NUM_CMD_INTERFACES = 4;
  localparam int DEF_NUM_CORES      = 8;
  localparam int DEF_CLUSTER_ID_W   = 2;

  // {cluster, core, local} layout for the default cluster size; trackers built
  // with other sizes declare the same field order with their own widths.
  typedef struct packed {
    logic [DEF_CLUSTER_ID_W-1:0]      cluster;
    logic [$clog2(DEF_NUM_CORES)-1:0] core;
    logic [$clog2(NUM_HPU_CMDS)-1:0]  local_id;
  } cmd_id_t;

  // A counter that must reach exactly `credits` needs one more code than credits.
  function automatic int cnt_w(input int credits);
    return $clog2(credits + 1);
  endfunction

endpackage

// File: rtl/pspin_cmd_tracker_if.sv
// Issue/response/completion bundle between the HPU drivers and the command
// slot tracker.
interface pspin_cmd_tracker_if #(
  parameter int NUM_CORES    = 8,
  parameter int NUM_HPU_CMDS = 4,
  parameter int NUM_CMD_INTF = 4,
  parameter int CLUSTER_ID_W = 2
);
  localparam int ID_W = CLUSTER_ID_W + $clog2(NUM_CORES) + $clog2(NUM_HPU_CMDS);

  // Allocation transfers on a cycle where req_valid_i && req_ready_o at the
  // rising clock edge; req_ready_o never looks at req_valid_i. Responses have
  // no ready and are consumed on every cycle resp_valid_i is high.
  logic                            req_valid_i;
  logic                            req_ready_o;
  logic [$clog2(NUM_CORES)-1:0]    req_core_i;
  logic [$clog2(NUM_CMD_INTF)-1:0] req_intf_i;
  logic [ID_W-1:0]                 req_cmd_id_o;
  logic                            resp_valid_i;
  logic [ID_W-1:0]                 resp_cmd_id_i;
  logic [NUM_CORES-1:0]            done_valid_o;
  logic [$clog2(NUM_HPU_CMDS)-1:0] done_local_id_o;

  modport slave (
    input  req_valid_i, req_core_i, req_intf_i, resp_valid_i, resp_cmd_id_i,
    output req_ready_o, req_cmd_id_o, done_valid_o, done_local_id_o
  );

  modport master (
    output req_valid_i, req_core_i, req_intf_i, resp_valid_i, resp_cmd_id_i,
    input  req_ready_o, req_cmd_id_o, done_valid_o, done_local_id_o
  );

endinterface

// File: rtl/pspin_first_free.sv
// Priority encoder over a free-slot mask: lowest set bit wins, empty when no
// bit is set.
module pspin_first_free #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]         free_mask,
  output logic [$clog2(WIDTH)-1:0] idx,
  output logic                     empty
);

  always_comb begin
    idx   = '0;
    empty = 1'b1;
    // Walk downwards so the last hit, the lowest index, is what remains.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (free_mask[i]) begin
        idx   = ($clog2(WIDTH))'(i);
        empty = 1'b0;
      end
    end
  end

endmodule

// File: rtl/pspin_cmd_tracker.sv
// Command-slot tracker: hands out per-core local command IDs, enforces a
// per-interface in-flight limit and retires commands on response.
module pspin_cmd_tracker #(
  parameter int NUM_CORES    = 8,
  parameter int NUM_HPU_CMDS = pspin_cfg_pkg::NUM_HPU_CMDS,
  parameter int NUM_CMD_INTF = pspin_cfg_pkg::NUM_CMD_INTERFACES,
  parameter int INTF_CREDITS = 16,
  parameter int CLUSTER_ID_W = 2
) (
  input  logic                                               clk_i,
  input  logic                                               rst_ni,
  input  logic [CLUSTER_ID_W-1:0]                            cluster_id_i,
  pspin_cmd_tracker_if.slave                                 cmd,
  output logic [NUM_CORES-1:0]                               core_busy_o,
  output logic [NUM_CMD_INTF-1:0][$clog2(INTF_CREDITS+1)-1:0] intf_inflight_o,
  output logic                                               err_o,
  input  logic                                               err_clr_i
);
  import pspin_cfg_pkg::cnt_w;

  localparam int CORE_W = $clog2(NUM_CORES);
  localparam int LOC_W  = $clog2(NUM_HPU_CMDS);
  localparam int INTF_W = $clog2(NUM_CMD_INTF);
  localparam int CNT_W  = cnt_w(INTF_CREDITS);
  localparam logic [CNT_W-1:0] CREDITS = CNT_W'(INTF_CREDITS);

  typedef struct packed {
    logic [CLUSTER_ID_W-1:0] cluster;
    logic [CORE_W-1:0]       core;
    logic [LOC_W-1:0]        local_id;
  } id_t;

  logic [NUM_CORES-1:0][NUM_HPU_CMDS-1:0]             slot_valid;
  logic [NUM_CORES-1:0][NUM_HPU_CMDS-1:0][INTF_W-1:0] slot_intf;
  logic [NUM_CMD_INTF-1:0][CNT_W-1:0]                 inflight;
  logic [NUM_CORES-1:0][LOC_W-1:0]                    free_idx;
  logic [NUM_CORES-1:0]                               no_free;
  logic [NUM_CMD_INTF-1:0]                            inc_vec;
  logic [NUM_CMD_INTF-1:0]                            dec_vec;

  id_t               issue_id;
  id_t               resp_id;
  logic              alloc;
  logic              resp_hit;
  logic              resp_miss;
  logic [INTF_W-1:0] resp_intf;
  logic              unused_resp_cluster;

  for (genvar c = 0; c < NUM_CORES; c++) begin : g_free
    pspin_first_free #(.WIDTH(NUM_HPU_CMDS)) u_first_free (
      .free_mask (~slot_valid[c]),
      .idx       (free_idx[c]),
      .empty     (no_free[c])
    );
  end

  assign cmd.req_ready_o = !no_free[cmd.req_core_i] &&
                           (inflight[cmd.req_intf_i] < CREDITS);

  always_comb begin
    issue_id.cluster  = cluster_id_i;
    issue_id.core     = cmd.req_core_i;
    issue_id.local_id = free_idx[cmd.req_core_i];
  end

  assign cmd.req_cmd_id_o = issue_id;
  assign alloc            = cmd.req_valid_i && cmd.req_ready_o;

  // The cluster field of a response is not trusted for routing.
  assign resp_id             = cmd.resp_cmd_id_i;
  assign unused_resp_cluster = ^resp_id.cluster;
  assign resp_hit  = cmd.resp_valid_i &&  slot_valid[resp_id.core][resp_id.local_id];
  assign resp_miss = cmd.resp_valid_i && !slot_valid[resp_id.core][resp_id.local_id];
  assign resp_intf = slot_intf[resp_id.core][resp_id.local_id];

  // Allocation only ever targets a free slot and a hit only a valid one, so
  // the two updates below can never land on the same slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_valid <= '0;
      slot_intf  <= '0;
    end else begin
      if (resp_hit) begin
        slot_valid[resp_id.core][resp_id.local_id] <= 1'b0;
      end
      if (alloc) begin
        slot_valid[cmd.req_core_i][issue_id.local_id] <= 1'b1;
        slot_intf[cmd.req_core_i][issue_id.local_id]  <= cmd.req_intf_i;
      end
    end
  end

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (alloc) begin
      inc_vec[cmd.req_intf_i] = 1'b1;
    end
    if (resp_hit) begin
      dec_vec[resp_intf] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight <= '0;
    end else begin
      for (int i = 0; i < NUM_CMD_INTF; i++) begin
        if (inc_vec[i] && !dec_vec[i]) begin
          inflight[i] <= inflight[i] + CNT_W'(1);
        end else if (dec_vec[i] && !inc_vec[i]) begin
          inflight[i] <= inflight[i] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmd.done_valid_o    <= '0;
      cmd.done_local_id_o <= '0;
      err_o               <= 1'b0;
    end else begin
      cmd.done_valid_o <= '0;
      if (resp_hit) begin
        cmd.done_valid_o[resp_id.core] <= 1'b1;
        cmd.done_local_id_o            <= resp_id.local_id;
      end
      if (resp_miss) begin
        err_o <= 1'b1;
      end else if (err_clr_i) begin
        err_o <= 1'b0;
      end
    end
  end

  always_comb begin
    core_busy_o = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      core_busy_o[c] = |slot_valid[c];
    end
  end

  assign intf_inflight_o = inflight;

endmodule

// File: tb/tb_pspin_cmd_tracker.sv
// Bench for pspin_cmd_tracker: slot-level model with per-cycle compare on a
// default-size instance, plus a two-credit instance for the credit limit.
module tb_pspin_cmd_tracker;

  localparam int NC = 8, NH = 4, NI = 4, CR = 16, CLW = 2, CR_B = 2;
  localparam int CORE_W = 3, LOC_W = 2, ID_W = 7, CNT_W = 5, CNT_W_B = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic [CLW-1:0] cluster_id = 2'b10;

  logic                     err_clr_a, err_a;
  logic [NC-1:0]            busy_a;
  logic [NI-1:0][CNT_W-1:0] infl_a;
  logic                       err_clr_b, err_b;
  logic [NC-1:0]              busy_b;
  logic [NI-1:0][CNT_W_B-1:0] infl_b;

  pspin_cmd_tracker_if #(.NUM_CORES(NC), .NUM_HPU_CMDS(NH), .NUM_CMD_INTF(NI),
                         .CLUSTER_ID_W(CLW)) bus_a ();
  pspin_cmd_tracker_if #(.NUM_CORES(NC), .NUM_HPU_CMDS(NH), .NUM_CMD_INTF(NI),
                         .CLUSTER_ID_W(CLW)) bus_b ();

  pspin_cmd_tracker #(.NUM_CORES(NC), .NUM_HPU_CMDS(NH), .NUM_CMD_INTF(NI),
                      .INTF_CREDITS(CR), .CLUSTER_ID_W(CLW)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .cluster_id_i(cluster_id), .cmd(bus_a),
    .core_busy_o(busy_a), .intf_inflight_o(infl_a), .err_o(err_a), .err_clr_i(err_clr_a)
  );

  pspin_cmd_tracker #(.NUM_CORES(NC), .NUM_HPU_CMDS(NH), .NUM_CMD_INTF(NI),
                      .INTF_CREDITS(CR_B), .CLUSTER_ID_W(CLW)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .cluster_id_i(cluster_id), .cmd(bus_b),
    .core_busy_o(busy_b), .intf_inflight_o(infl_b), .err_o(err_b), .err_clr_i(err_clr_b)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: one busy flag and interface per slot ----------------
  bit           m_valid [NC][NH];
  int           m_intf  [NC][NH];
  bit           m_err;
  logic [NC-1:0] m_done_v;
  int           m_done_l;

  function automatic int m_first_free(input int c);
    for (int l = 0; l < NH; l++) if (!m_valid[c][l]) return l;
    return -1;
  endfunction

  function automatic int m_count(input int i);
    int n = 0;
    for (int c = 0; c < NC; c++)
      for (int l = 0; l < NH; l++)
        if (m_valid[c][l] && m_intf[c][l] == i) n++;
    return n;
  endfunction

  function automatic bit m_busy(input int c);
    for (int l = 0; l < NH; l++) if (m_valid[c][l]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_ready(input int c, input int i);
    return (m_first_free(c) >= 0) && (m_count(i) < CR);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int rc, rl, ac, al;
    bit hit;
    if (!rst_n) begin
      for (int c = 0; c < NC; c++)
        for (int l = 0; l < NH; l++) begin
          m_valid[c][l] <= 1'b0;
          m_intf[c][l]  <= 0;
        end
      m_err    <= 1'b0;
      m_done_v <= '0;
      m_done_l <= 0;
    end else begin
      rc  = int'(bus_a.resp_cmd_id_i[LOC_W +: CORE_W]);
      rl  = int'(bus_a.resp_cmd_id_i[LOC_W-1:0]);
      hit = bus_a.resp_valid_i && m_valid[rc][rl];
      m_done_v <= '0;
      if (hit) begin
        m_valid[rc][rl] <= 1'b0;
        m_done_v[rc]    <= 1'b1;
        m_done_l        <= rl;
      end
      if (bus_a.resp_valid_i && !hit) m_err <= 1'b1;
      else if (err_clr_a) m_err <= 1'b0;
      ac = int'(bus_a.req_core_i);
      if (bus_a.req_valid_i && m_ready(ac, int'(bus_a.req_intf_i))) begin
        al = m_first_free(ac);
        m_valid[ac][al] <= 1'b1;
        m_intf[ac][al]  <= int'(bus_a.req_intf_i);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    int c, i, ff;
    logic [NC-1:0] exp_busy;
    if (chk_en) begin
      c  = int'(bus_a.req_core_i);
      i  = int'(bus_a.req_intf_i);
      ff = m_first_free(c);
      check("req_ready", bus_a.req_ready_o, m_ready(c, i));
      if (ff >= 0) check("req_cmd_id", bus_a.req_cmd_id_o, {cluster_id, CORE_W'(c), LOC_W'(ff)});
      for (int k = 0; k < NC; k++) exp_busy[k] = m_busy(k);
      check("core_busy", busy_a, exp_busy);
      for (int k = 0; k < NI; k++) check("intf_inflight", infl_a[k], m_count(k));
      check("err", err_a, m_err);
      check("done_valid", bus_a.done_valid_o, m_done_v);
      check("done_local_id", bus_a.done_local_id_o, m_done_l);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_a(input bit v, input int core, input int intf, input bit rv,
                         input logic [ID_W-1:0] rid, input bit clr);
    @(posedge clk);
    #1;
    bus_a.req_valid_i   = v;
    bus_a.req_core_i    = CORE_W'(core);
    bus_a.req_intf_i    = 2'(intf);
    bus_a.resp_valid_i  = rv;
    bus_a.resp_cmd_id_i = rid;
    err_clr_a           = clr;
    #2;
  endtask

  task automatic drive_b(input bit v, input int core, input int intf, input bit rv,
                         input logic [ID_W-1:0] rid);
    @(posedge clk);
    #1;
    bus_b.req_valid_i   = v;
    bus_b.req_core_i    = CORE_W'(core);
    bus_b.req_intf_i    = 2'(intf);
    bus_b.resp_valid_i  = rv;
    bus_b.resp_cmd_id_i = rid;
    #2;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    bus_a.req_valid_i = 0; bus_a.req_core_i = 0; bus_a.req_intf_i = 0;
    bus_a.resp_valid_i = 0; bus_a.resp_cmd_id_i = 0; err_clr_a = 0;
    bus_b.req_valid_i = 0; bus_b.req_core_i = 0; bus_b.req_intf_i = 0;
    bus_b.resp_valid_i = 0; bus_b.resp_cmd_id_i = 0; err_clr_b = 0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    #2;
    check("rst_ready", bus_a.req_ready_o, 1'b1);
    check("rst_busy", busy_a, 0);
    check("rst_inflight", infl_a, 0);
    check("rst_err", err_a, 0);
    check("rst_done_valid", bus_a.done_valid_o, 0);
    check("rst_done_local", bus_a.done_local_id_o, 0);

    // Core 2 / interface 1: four allocations, then the core is full.
    for (int k = 0; k < 4; k++) begin
      drive_a(1, 2, 1, 0, 7'h00, 0);
      check("alloc_id", bus_a.req_cmd_id_o, 64'h48 + 64'(k));
      check("alloc_ready", bus_a.req_ready_o, 1'b1);
    end
    drive_a(1, 2, 1, 0, 7'h00, 0);
    check("full_ready", bus_a.req_ready_o, 1'b0);
    check("full_inflight1", infl_a[1], 4);
    check("full_busy", busy_a, 8'b0000_0100);

    // Retire {core 2, local 1}; local 1 is the next one reissued.
    drive_a(0, 0, 0, 1, 7'h09, 0);
    drive_a(1, 2, 1, 0, 7'h00, 0);
    check("done_valid_core2", bus_a.done_valid_o, 8'b0000_0100);
    check("done_local_1", bus_a.done_local_id_o, 1);
    check("realloc_id", bus_a.req_cmd_id_o, 7'h49);
    drive_a(0, 0, 0, 0, 7'h00, 0);
    check("done_pulse_end", bus_a.done_valid_o, 0);
    check("done_local_hold", bus_a.done_local_id_o, 1);

    // Same-cycle allocate and retire on core 0 / interface 0.
    drive_a(1, 0, 0, 0, 7'h00, 0);
    check("c0_first_id", bus_a.req_cmd_id_o, 7'h40);
    drive_a(1, 0, 0, 1, 7'h00, 0);
    check("c0_same_cycle_id", bus_a.req_cmd_id_o, 7'h41);
    check("c0_inflight_before", infl_a[0], 1);
    drive_a(0, 0, 0, 0, 7'h00, 0);
    check("c0_inflight_after", infl_a[0], 1);
    check("c0_local0_free", bus_a.req_cmd_id_o, 7'h40);
    check("c0_done_valid", bus_a.done_valid_o, 8'b0000_0001);

    // Response to a never-allocated {core 5, local 3}.
    drive_a(0, 0, 0, 1, 7'h17, 0);
    drive_a(0, 0, 0, 0, 7'h00, 0);
    check("miss_err", err_a, 1);
    check("miss_no_done", bus_a.done_valid_o, 0);
    check("miss_inflight", infl_a, 20'h00081);
    drive_a(0, 0, 0, 0, 7'h00, 1);
    check("clr_pending", err_a, 1);
    drive_a(0, 0, 0, 0, 7'h00, 0);
    check("clr_done", err_a, 0);
    drive_a(0, 0, 0, 1, 7'h17, 1);
    drive_a(0, 0, 0, 0, 7'h00, 0);
    check("err_set_wins", err_a, 1);
    drive_a(0, 0, 0, 0, 7'h00, 1);
    drive_a(0, 0, 0, 0, 7'h00, 0);

    // Sixth outstanding command, then asynchronous reset mid-cycle.
    drive_a(1, 3, 2, 0, 7'h00, 0);
    drive_a(0, 0, 0, 0, 7'h00, 0);
    check("six_busy", busy_a, 8'b0000_1101);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_inflight", infl_a, 0);
    check("mid_rst_ready", bus_a.req_ready_o, 1'b1);
    check("mid_rst_done", bus_a.done_valid_o, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive_a(0, 0, 0, 1, 7'h48, 0);
    drive_a(0, 0, 0, 0, 7'h00, 0);
    check("post_rst_err", err_a, 1);
    check("post_rst_no_done", bus_a.done_valid_o, 0);
    drive_a(0, 0, 0, 0, 7'h00, 1);

    // Mixed traffic checked against the model every cycle.
    for (int n = 0; n < 300; n++) begin
      drive_a($urandom_range(0, 1), $urandom_range(0, NC - 1), $urandom_range(0, NI - 1),
              $urandom_range(0, 1), ID_W'($urandom_range(0, 127)), $urandom_range(0, 15) == 0);
    end
    drive_a(0, 0, 0, 0, 7'h00, 0);

    // Two-credit instance: cores 0 and 1 share interface 3.
    drive_b(1, 0, 3, 0, 7'h00);
    check("b_first_ready", bus_b.req_ready_o, 1'b1);
    drive_b(1, 1, 3, 0, 7'h00);
    check("b_second_ready", bus_b.req_ready_o, 1'b1);
    drive_b(1, 0, 3, 0, 7'h00);
    check("b_credit_stall", bus_b.req_ready_o, 1'b0);
    check("b_inflight3_full", infl_b[3], 2);
    check("b_busy", busy_b, 8'b0000_0011);
    drive_b(1, 0, 3, 1, 7'h00);
    check("b_stall_resp_cycle", bus_b.req_ready_o, 1'b0);
    drive_b(1, 0, 3, 0, 7'h00);
    check("b_credit_reopen", bus_b.req_ready_o, 1'b1);
    check("b_inflight3_one", infl_b[3], 1);
    check("b_done_valid", bus_b.done_valid_o, 8'b0000_0001);
    drive_b(0, 0, 0, 0, 7'h00);
    check("b_inflight3_refill", infl_b[3], 2);
    check("b_err", err_b, 0);

    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
